// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types and constants for the seven-segment scan controller.
// Holds the scan state enum, the blank segment pattern, the active-low hex
// glyph table ({a,b,c,d,e,f,g,dp}, dp bit left off) and a counter width helper.
package sseg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry k is the glyph for hex digit k; bit 0 (dp) is always 1 (off) here.
    localparam logic [15:0][7:0] GLYPHS = {
        8'h71, 8'h61, 8'h85, 8'h63,   // F E d C
        8'hC1, 8'h11, 8'h09, 8'h01,   // b A 9 8
        8'h1F, 8'h41, 8'h49, 8'h99,   // 7 6 5 4
        8'h0D, 8'h25, 8'h9F, 8'h03    // 3 2 1 0
    };

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_sseg.sv
// hex_sseg: combinational hex nibble + decimal point to active-low segments.
module hex_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] i_hex,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    // Glyph lookup with the dp segment driven low when the point is lit.
    always_comb begin
        o_seg = {GLYPHS[i_hex][7:1], ~i_dp};
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexed scan controller for an N-digit
// common-anode seven-segment display with inter-digit blanking and
// frame-atomic updates through a valid/ready write port.
// Optional leading-zero suppression is enabled by defining SSEG_LZ_BLANK_EN.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int N_DIGITS     = 3,
    parameter int DWELL_CYCLES = 4000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*N_DIGITS-1:0] wr_data,
    input  logic [N_DIGITS-1:0]   wr_dp,
    output logic [7:0]            seg_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  frame_tick
);

    localparam int PW = cntWidth((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES);
    localparam int IW = cntWidth(N_DIGITS);
    localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL_CYCLES - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [PW-1:0]         r_phase;
    logic [4*N_DIGITS-1:0] r_actData;
    logic [N_DIGITS-1:0]   r_actDp;
    logic [4*N_DIGITS-1:0] r_pendData;
    logic [N_DIGITS-1:0]   r_pendDp;
    logic                  r_pendValid;
    logic [7:0]            r_seg;
    logic [N_DIGITS-1:0]   r_an;
    logic                  r_tick;

    logic                  w_showDone;
    logic                  w_blankDone;
    logic                  w_frameEnd;
    logic                  w_commit;
    logic                  w_enterShow;
    logic [IW-1:0]         w_nextIdx;
    logic [4*N_DIGITS-1:0] w_viewData;
    logic [N_DIGITS-1:0]   w_viewDp;
    logic [3:0]            w_nibble;
    logic                  w_dpSel;
    logic                  w_litSel;
    logic [N_DIGITS-1:0]   w_lit;
    logic [N_DIGITS-1:0]   w_anShow;
    logic [7:0]            w_decSeg;

    assign w_showDone  = (r_state == SHOW) && (r_phase == DWELL_LAST);
    assign w_blankDone = (r_state == BLANK) && ((BLANK_CYCLES == 0) || (r_phase == BLANK_LAST));
    assign w_frameEnd  = w_showDone && (r_idx == IDX_LAST);
    assign w_commit    = w_frameEnd && r_pendValid;
    assign w_enterShow = w_blankDone || (w_showDone && (BLANK_CYCLES == 0));
    assign w_nextIdx   = w_showDone ? ((r_idx == IDX_LAST) ? '0 : r_idx + IW'(1)) : r_idx;

    // A digit entered on a commit edge must already see the freshly committed value.
    assign w_viewData  = w_commit ? r_pendData : r_actData;
    assign w_viewDp    = w_commit ? r_pendDp   : r_actDp;

    assign wr_ready    = ~r_pendValid;
    assign seg_n       = r_seg;
    assign an_n        = r_an;
    assign frame_tick  = r_tick;

    // Decide which digits are lit; leading zeros go dark only when suppression is built in.
    always_comb begin
        logic anyNz;
        anyNz = 1'b0;
        w_lit = '1;
`ifdef SSEG_LZ_BLANK_EN
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            anyNz    = anyNz | (|w_viewData[4*k +: 4]) | w_viewDp[k];
            w_lit[k] = anyNz || (k == 0);
        end
`endif
    end

    // Select the nibble, point and anode pattern of the digit about to be shown.
    always_comb begin
        w_nibble = '0;
        w_dpSel  = 1'b0;
        w_litSel = 1'b0;
        w_anShow = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (w_nextIdx == IW'(k)) begin
                w_nibble    = w_viewData[4*k +: 4];
                w_dpSel     = w_viewDp[k];
                w_litSel    = w_lit[k];
                w_anShow[k] = 1'b0;
            end
        end
    end

    hex_sseg u_dec (
        .i_hex (w_nibble),
        .i_dp  (w_dpSel),
        .o_seg (w_decSeg)
    );

    // Scan FSM: phase timing, digit stepping and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BLANK;
            r_idx   <= '0;
            r_phase <= '0;
            r_seg   <= SEG_OFF;
            r_an    <= '1;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_frameEnd;
            case (r_state)
                BLANK: begin
                    if (w_blankDone) begin
                        r_state <= SHOW;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                SHOW: begin
                    if (w_showDone) begin
                        r_state <= (BLANK_CYCLES == 0) ? SHOW : BLANK;
                        r_phase <= '0;
                        r_idx   <= w_nextIdx;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                default: begin
                    r_state <= BLANK;
                    r_phase <= '0;
                end
            endcase
            if (w_enterShow) begin
                r_an  <= w_litSel ? w_anShow : '1;
                r_seg <= w_litSel ? w_decSeg : SEG_OFF;
            end else if (w_showDone) begin
                r_an  <= '1;
                r_seg <= SEG_OFF;
            end
        end
    end

    // Write handshake into the pending buffer and frame-boundary commit to active.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_actData   <= '0;
            r_actDp     <= '0;
            r_pendData  <= '0;
            r_pendDp    <= '0;
            r_pendValid <= 1'b0;
        end else begin
            if (w_commit) begin
                r_actData   <= r_pendData;
                r_actDp     <= r_pendDp;
                r_pendValid <= 1'b0;
            end
            if (wr_valid && !r_pendValid) begin
                r_pendData  <= wr_data;
                r_pendDp    <= wr_dp;
                r_pendValid <= 1'b1;
            end
        end
    end

endmodule
